// File: rtl/latch_bank_arb.sv
// Round-robin write sequencer for a shared bank of level-sensitive latches.
// Each grant runs setup / open / hold so latch_d never moves while latch_en is high.
module latch_bank_arb #(
  parameter int WIDTH       = 8,
  parameter int OPEN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             latch_en,
  output logic [WIDTH-1:0] latch_d,
  input  logic [WIDTH-1:0] latch_q,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(OPEN_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, ACK} state_t;

  state_t           state_q;
  logic             sel_q;
  logic             last_q;
  logic [CW-1:0]    cnt_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             latch_en_q;
  logic [WIDTH-1:0] latch_d_q;
  logic             busy_q;
  logic             err_q;
  logic             win_d;

  // A tie goes to whoever was not served most recently.
  assign win_d = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      latch_en_q <= 1'b0;
      latch_d_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            sel_q     <= win_d;
            latch_d_q <= win_d ? data1 : data0;
            busy_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          cnt_q      <= CW'(OPEN_CYCLES - 1);
          latch_en_q <= 1'b1;
          state_q    <= OPEN;
        end
        OPEN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            latch_en_q <= 1'b0;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (latch_q != latch_d_q) begin
            err_q <= 1'b1;
          end
          ack0_q  <= ~sel_q;
          ack1_q  <= sel_q;
          state_q <= ACK;
        end
        ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= sel_q;
          state_q <= IDLE;
        end
        default: begin
          ack0_q     <= 1'b0;
          ack1_q     <= 1'b0;
          latch_en_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign latch_en = latch_en_q;
  assign latch_d  = latch_d_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule
